// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator.
// Holds the 640x480@60 Hz timing defaults, the counter and pixel bus widths,
// and the coordinate value reported outside the request window.
package vga_pkg;

    // 640x480@60 Hz horizontal timing, in pixel clocks
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;
    localparam int H_VALID_DEF = 640;
    localparam int H_TOTAL_DEF = 800;

    // 640x480@60 Hz vertical timing, in lines
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;
    localparam int V_VALID_DEF = 480;
    localparam int V_TOTAL_DEF = 525;

    // Counter / coordinate width and RGB565 bus width
    localparam int CNT_W = 10;
    localparam int RGB_W = 16;

    // Coordinate value driven while no pixel is being requested
    localparam logic [CNT_W-1:0] IDLE_COORD = 10'h3FF;

    // True when val lies in the inclusive range [lo, hi].
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_ctrl.sv
// VGA timing generator.
// Two free-running counters (pixel within line, line within frame) drive every
// output through combinational decodes. Pixel data is requested one clock
// before it is shown, so the request window sits one clock ahead of the
// active-video window on the horizontal axis.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_VALID = H_VALID_DEF,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
)(
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [RGB_W-1:0] pix_data,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_data_req,
    output logic             rgb_valid,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    // Counter wrap points
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Sync regions start at 0 and end just before these values
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);

    // Active-video windows (inclusive bounds)
    localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_VALID - 1);

    // Request window: one clock ahead of active video horizontally
    localparam logic [CNT_W-1:0] H_REQ_LO = CNT_W'(H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] H_REQ_HI = CNT_W'(H_SYNC + H_BACK + H_VALID - 2);

    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_v;
    logic             h_last;
    logic             v_last;
    logic             h_act;
    logic             h_req;
    logic             v_act;

    assign h_last = (cnt_h == H_LAST);
    assign v_last = (cnt_v == V_LAST);

    // Pixel counter: steps every clock, wraps at the end of the line
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
        end else if (h_last) begin
            cnt_h <= '0;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    // Line counter: steps on the last pixel of each line, wraps with the frame
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v <= '0;
        end else if (h_last) begin
            if (v_last) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 1'b1;
            end
        end
    end

    // Window decodes and coordinate generation from the current counter values
    always_comb begin
        h_act        = in_range(cnt_h, H_ACT_LO, H_ACT_HI);
        h_req        = in_range(cnt_h, H_REQ_LO, H_REQ_HI);
        v_act        = in_range(cnt_v, V_ACT_LO, V_ACT_HI);

        hsync        = (cnt_h < H_SYNC_END);
        vsync        = (cnt_v < V_SYNC_END);
        rgb_valid    = h_act && v_act;
        pix_data_req = h_req && v_act;

        pix_x        = IDLE_COORD;
        pix_y        = IDLE_COORD;
        if (pix_data_req) begin
            pix_x = cnt_h - H_REQ_LO;
            pix_y = cnt_v - V_ACT_LO;
        end

        rgb = rgb_valid ? pix_data : '0;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Testbench for vga_ctrl.
// Two instances run from the same clock and reset: one with the 640x480
// defaults and one with a scaled-down timing (40 clocks x 20 lines) so that
// whole frames fit in a short run. A cycle-count model derives every output
// from the clock count since reset release.
module tb_vga_ctrl;

    // Scaled-down timing for the second instance
    localparam int S_HS = 8;
    localparam int S_HB = 6;
    localparam int S_HV = 20;
    localparam int S_HT = 40;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int S_VV = 10;
    localparam int S_VT = 20;

    localparam logic [39:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};

    logic        vga_clk;
    logic        sys_rst_n;

    logic [15:0] pix_data_d, pix_data_s;
    logic [9:0]  pix_x_d, pix_y_d, pix_x_s, pix_y_s;
    logic        req_d, valid_d, hsync_d, vsync_d;
    logic        req_s, valid_s, hsync_s, vsync_s;
    logic [15:0] rgb_d, rgb_s;
    logic [39:0] obs_d, obs_s;

    int checks = 0;
    int errors = 0;
    int n_model = 0;

    vga_ctrl dut_def (
        .vga_clk      (vga_clk),
        .sys_rst_n    (sys_rst_n),
        .pix_data     (pix_data_d),
        .pix_x        (pix_x_d),
        .pix_y        (pix_y_d),
        .pix_data_req (req_d),
        .rgb_valid    (valid_d),
        .hsync        (hsync_d),
        .vsync        (vsync_d),
        .rgb          (rgb_d)
    );

    vga_ctrl #(
        .H_SYNC (S_HS), .H_BACK (S_HB), .H_VALID (S_HV), .H_TOTAL (S_HT),
        .V_SYNC (S_VS), .V_BACK (S_VB), .V_VALID (S_VV), .V_TOTAL (S_VT)
    ) dut_sml (
        .vga_clk      (vga_clk),
        .sys_rst_n    (sys_rst_n),
        .pix_data     (pix_data_s),
        .pix_x        (pix_x_s),
        .pix_y        (pix_y_s),
        .pix_data_req (req_s),
        .rgb_valid    (valid_s),
        .hsync        (hsync_s),
        .vsync        (vsync_s),
        .rgb          (rgb_s)
    );

    assign obs_d = {hsync_d, vsync_d, req_d, valid_d, pix_x_d, pix_y_d, rgb_d};
    assign obs_s = {hsync_s, vsync_s, req_s, valid_s, pix_x_s, pix_y_s, rgb_s};

    // Picture generator colour for a coordinate
    function automatic logic [15:0] pattern(input logic [9:0] x, input logic [9:0] y);
        return {x[4:0], y[5:0], x[4:0]};
    endfunction

    // Expected outputs n clocks after reset release for the given timing
    function automatic logic [39:0] expectOut(input int n,
                                              input int hs, input int hb, input int hv, input int ht,
                                              input int vs, input int vb, input int vv, input int vt);
        int h, v;
        logic hs_o, vs_o, vwin, valid, req;
        logic [9:0] px, py;
        logic [15:0] col;
        h     = n % ht;
        v     = (n / ht) % vt;
        hs_o  = (h < hs);
        vs_o  = (v < vs);
        vwin  = (v >= vs + vb) && (v < vs + vb + vv);
        valid = vwin && (h >= hs + hb) && (h < hs + hb + hv);
        req   = vwin && (h >= hs + hb - 1) && (h < hs + hb + hv - 1);
        px    = req ? 10'(h - (hs + hb - 1)) : 10'h3FF;
        py    = req ? 10'(v - (vs + vb)) : 10'h3FF;
        col   = valid ? pattern(10'(h - (hs + hb)), 10'(v - (vs + vb))) : 16'h0000;
        return {hs_o, vs_o, req, valid, px, py, col};
    endfunction

    // One comparison: count it, report it if the values differ
    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drive reset and let a number of falling clock edges pass
    task automatic applyStimulus(input logic rst_val, input int cycles);
        sys_rst_n = rst_val;
        repeat (cycles) @(negedge vga_clk);
    endtask

    // 25 MHz pixel clock
    initial begin
        vga_clk = 1'b0;
        forever #20 vga_clk = ~vga_clk;
    end

    // Clocks elapsed since reset release
    always @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) n_model <= 0;
        else            n_model <= n_model + 1;
    end

    // Picture generator: registers the colour for the coordinate requested last clock
    initial begin
        logic [9:0] cx_d, cy_d, cx_s, cy_s;
        pix_data_d = 16'h0000;
        pix_data_s = 16'h0000;
        forever begin
            @(negedge vga_clk);
            cx_d = pix_x_d; cy_d = pix_y_d;
            cx_s = pix_x_s; cy_s = pix_y_s;
            @(posedge vga_clk);
            #1;
            pix_data_d = pattern(cx_d, cy_d);
            pix_data_s = pattern(cx_s, cy_s);
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge vga_clk) begin
        if (sys_rst_n) begin
            checkOutput("model_def", obs_d, expectOut(n_model, 96, 48, 640, 800, 2, 33, 480, 525));
            checkOutput("model_sml", obs_s, expectOut(n_model, S_HS, S_HB, S_HV, S_HT, S_VS, S_VB, S_VV, S_VT));
        end else begin
            checkOutput("reset_def", obs_d, RESET_OUT);
            checkOutput("reset_sml", obs_s, RESET_OUT);
        end
    end

    // Directed sequence
    initial begin
        int hs_fall, hs_cnt, sv_cnt, sv_valid, sv_rise, sv_first_rise;
        int val_cnt, req_cnt, first_val, last_val, ramp_err, fall2;
        logic prev_vs;
        logic [39:0] pin;

        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_hold_def", obs_d, RESET_OUT);
        checkOutput("rst_hold_sml", obs_s, RESET_OUT);

        pin = expectOut(28000 + 782, 96, 48, 640, 800, 2, 33, 480, 525);
        checkOutput("model_pin_782", pin, {1'b0, 1'b0, 1'b1, 1'b1, 10'd639, 10'd0, 16'hF01E});

        // Release 200 ns in, just after a falling edge
        #204;
        sys_rst_n = 1'b1;
        #1;

        // First two small frames and the first default line
        hs_fall = -1; hs_cnt = 0; sv_cnt = 0; sv_valid = 0; sv_rise = 0; sv_first_rise = -1;
        prev_vs = vsync_s;
        for (int i = 0; i <= 1600; i++) begin
            if (i > 0) @(negedge vga_clk);
            if (!hsync_d && hs_fall < 0) hs_fall = i;
            if (i < 800) begin
                hs_cnt   += int'(hsync_d);
                sv_cnt   += int'(vsync_s);
                sv_valid += int'(valid_s);
            end
            if (i > 0 && vsync_s && !prev_vs) begin
                sv_rise++;
                if (sv_first_rise < 0) sv_first_rise = i;
            end
            prev_vs = vsync_s;
            if (i == 592) checkOutput("sml_last_req", 40'({req_s, pix_x_s, pix_y_s}), 40'({1'b1, 10'd19, 10'd9}));
            if (i == 613) checkOutput("sml_after_last", 40'({req_s, pix_x_s, pix_y_s}), 40'({1'b0, 10'h3FF, 10'h3FF}));
        end
        checkOutput("hsync_fall", 40'(hs_fall), 40'd96);
        checkOutput("hsync_width", 40'(hs_cnt), 40'd96);
        checkOutput("sml_vsync_width", 40'(sv_cnt), 40'd80);
        checkOutput("sml_active_clocks", 40'(sv_valid), 40'd200);
        checkOutput("sml_frame_start", 40'(sv_first_rise), 40'd800);
        checkOutput("sml_frame_count", 40'(sv_rise), 40'd2);

        // Advance to line 35 of the default instance
        applyStimulus(1'b1, 28000 - 1600);
        val_cnt = 0; req_cnt = 0; first_val = -1; last_val = -1; ramp_err = 0; hs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            hs_cnt += int'(hsync_d);
            if (valid_d) begin
                val_cnt++;
                if (first_val < 0) first_val = i;
                last_val = i;
            end
            if (req_d) begin
                req_cnt++;
                if (pix_x_d != 10'(i - 143) || pix_y_d != 10'd0) ramp_err++;
            end
            if (i == 200) checkOutput("rgb_pixel_56", 40'(rgb_d), 40'h0000C018);
            if (i == 782) checkOutput("last_req_782", 40'({req_d, pix_x_d, pix_y_d}), 40'({1'b1, 10'd639, 10'd0}));
            if (i == 783) checkOutput("last_valid_783", 40'({valid_d, req_d}), 40'({1'b1, 1'b0}));
            if (i == 784) checkOutput("blank_784", 40'({valid_d, rgb_d}), 40'd0);
            @(negedge vga_clk);
        end
        checkOutput("line35_valid_cnt", 40'(val_cnt), 40'd640);
        checkOutput("line35_first_valid", 40'(first_val), 40'd144);
        checkOutput("line35_last_valid", 40'(last_val), 40'd783);
        checkOutput("line35_req_cnt", 40'(req_cnt), 40'd640);
        checkOutput("line35_ramp", 40'(ramp_err), 40'd0);
        checkOutput("line35_hsync_width", 40'(hs_cnt), 40'd96);

        // Mid-line reset at cnt_h=400 of line 36
        applyStimulus(1'b1, 400);
        #5;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_def", obs_d, RESET_OUT);
        checkOutput("async_rst_sml", obs_s, RESET_OUT);
        applyStimulus(1'b0, 3);
        #5;
        sys_rst_n = 1'b1;
        #1;
        checkOutput("restart_def", obs_d, RESET_OUT);
        fall2 = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge vga_clk);
            if (!hsync_d && fall2 < 0) fall2 = i;
        end
        checkOutput("restart_hsync_fall", 40'(fall2), 40'd96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
